fir_out_requant: RTL

Downstream stage of the FIR filter. Takes the filter's wide signed output, applies a programmable arithmetic right shift with round-half-up, and saturates the result to a narrow signed sample. A small output FIFO with valid/ready handshaking sits behind the arithmetic pipeline. A saturating counter records how many samples were clipped.

---
 rtl/fir_out_requant.sv | 110 +++++++++++
 1 files changed

// File: rtl/fir_out_requant.sv
// Requantiser behind the FIR filter: rounding arithmetic right shift, saturation to OUT_W,
// and a small credit-controlled output FIFO with clip accounting.
module fir_out_requant #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 4,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  input  logic [SHIFT_W-1:0] in_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [7:0]         sat_count,
  output logic               sat_flag
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam int SW = IN_W + 1;
  localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (OUT_W - 1)));

  logic                    v1, v2, clip2;
  logic signed [SW-1:0]    s1;
  logic [OUT_W-1:0]        s2;
  logic [OUT_W-1:0]        mem [DEPTH];
  logic [AW-1:0]           wp, rp;
  logic [CW-1:0]           count;

  logic signed [SW-1:0]    ext, rnd, sum;
  logic [OUT_W-1:0]        sat_val;
  logic                    clip_c;
  logic                    accept, push, pop;

  // One extra bit keeps the half-LSB rounding add from wrapping at the positive limit.
  always_comb begin
    ext = {in_data[IN_W-1], in_data};
    rnd = '0;
    if (in_shift != '0)
      rnd = SW'(1) << (in_shift - SHIFT_W'(1));
    sum = ext + rnd;
  end

  always_comb begin
    sat_val = s1[OUT_W-1:0];
    clip_c  = 1'b0;
    if (s1 > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_W-1:0];
      clip_c  = 1'b1;
    end else if (s1 < SAT_MIN) begin
      sat_val = SAT_MIN[OUT_W-1:0];
      clip_c  = 1'b1;
    end
  end

  // Credits cover the FIFO plus both pipeline slots, so a push never meets a full FIFO.
  always_comb begin
    in_ready  = (count + CW'(v1) + CW'(v2)) < CW'(DEPTH);
    out_valid = (count != '0);
    out_data  = mem[rp];
    accept    = in_valid && in_ready;
    push      = v2;
    pop       = out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      clip2     <= 1'b0;
      s1        <= '0;
      s2        <= '0;
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      sat_count <= '0;
      sat_flag  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      v1    <= accept;
      v2    <= v1;
      s2    <= sat_val;
      clip2 <= clip_c;
      if (accept)
        s1 <= sum >>> in_shift;
      if (push) begin
        mem[wp] <= s2;
        wp      <= wp + AW'(1);
        if (clip2) begin
          sat_flag <= 1'b1;
          if (sat_count != 8'hFF)
            sat_count <= sat_count + 8'd1;
        end
      end
      if (pop)
        rp <= rp + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

endmodule
